// File: rtl/gon_collect_controller.sv
// gon_collect_controller
//   PE-side output controller for the global output network (GON).
//   Result words from one PE are queued in a small FIFO and offered on the
//   shared output bus only while the bus tag matches this controller's ID.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   set_id, id_in     load a new ID (also clears sent_cnt)
//   id                current ID register
//   tag               bus destination tag for this cycle
//   pe_valid/pe_data  PE offers a result word
//   pe_ready          FIFO has a free slot (registered-state only)
//   bus_ready         bus accepts the offered word
//   bus_valid         head word offered (tag match and FIFO not empty)
//   bus_data          FIFO head, 0 when empty (not gated by tag)
//   pending           number of occupied FIFO entries
//   sent_cnt          words accepted by the bus since reset / last set_id
module gon_collect_controller #(
  parameter int ID_SIZE   = 5,
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_SIZE  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_id,
  input  logic [ID_SIZE-1:0]         id_in,
  output logic [ID_SIZE-1:0]         id,
  input  logic [ID_SIZE-1:0]         tag,
  input  logic                       pe_valid,
  input  logic [DATA_SIZE-1:0]       pe_data,
  output logic                       pe_ready,
  input  logic                       bus_ready,
  output logic                       bus_valid,
  output logic [DATA_SIZE-1:0]       bus_data,
  output logic [$clog2(DEPTH):0]     pending,
  output logic [CNT_SIZE-1:0]        sent_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        pend_q, pend_d;
  logic [CNT_SIZE-1:0]  sent_q, sent_d;
  logic [ID_SIZE-1:0]   id_q, id_d;
  logic                 push, pop;

  // pe_ready depends only on registered occupancy; a pop this cycle does not
  // open a slot until the next cycle.
  assign pe_ready  = (pend_q < DEPTH_C);
  assign bus_valid = (tag == id_q) && (pend_q != '0);
  assign bus_data  = (pend_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign push      = pe_valid && pe_ready;
  assign pop       = bus_valid && bus_ready;

  assign id       = id_q;
  assign pending  = pend_q;
  assign sent_cnt = sent_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pend_d   = pend_q;
    sent_d   = sent_q;
    id_d     = id_q;
    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      sent_d   = sent_q + CNT_SIZE'(1);
    end
    case ({push, pop})
      2'b10:   pend_d = pend_q + PW'(1);
      2'b01:   pend_d = pend_q - PW'(1);
      default: pend_d = pend_q;
    endcase
    // set_id wins over a same-cycle pop: the counter restarts at 0.
    if (set_id) begin
      id_d   = id_in;
      sent_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= '0;
      sent_q   <= '0;
      id_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      sent_q   <= sent_d;
      id_q     <= id_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pe_data;
  end

endmodule

// File: tb/tb_gon_collect_controller.sv
module tb_gon_collect_controller;

  localparam int ID_SIZE   = 5;
  localparam int DATA_SIZE = 32;
  localparam int DEPTH     = 2;
  localparam int CNT_SIZE  = 16;
  localparam int PW        = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 set_id;
  logic [ID_SIZE-1:0]   id_in;
  logic [ID_SIZE-1:0]   id;
  logic [ID_SIZE-1:0]   tag;
  logic                 pe_valid;
  logic [DATA_SIZE-1:0] pe_data;
  logic                 pe_ready;
  logic                 bus_ready;
  logic                 bus_valid;
  logic [DATA_SIZE-1:0] bus_data;
  logic [PW-1:0]        pending;
  logic [CNT_SIZE-1:0]  sent_cnt;

  gon_collect_controller #(
    .ID_SIZE(ID_SIZE), .DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .CNT_SIZE(CNT_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .set_id(set_id), .id_in(id_in), .id(id), .tag(tag),
    .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready),
    .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
    .pending(pending), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of words, ID, sent counter.
  logic [DATA_SIZE-1:0] mq[$];
  int                   m_id;
  int                   m_sent;
  int                   n_pops;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Check every output against the model's current state.
  task automatic check_outputs();
    logic exp_bv;
    exp_bv = (int'(tag) == m_id) && (mq.size() != 0);
    chk("id",        64'(id),        64'(m_id));
    chk("pe_ready",  64'(pe_ready),  64'(mq.size() < DEPTH));
    chk("bus_valid", 64'(bus_valid), 64'(exp_bv));
    chk("bus_data",  64'(bus_data),  (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
    chk("pending",   64'(pending),   64'(mq.size()));
    chk("sent_cnt",  64'(sent_cnt),  64'(m_sent));
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic cyc(input logic sid, input int idv, input int tg, input logic pv,
                     input logic [DATA_SIZE-1:0] pd, input logic br);
    logic do_push, do_pop;
    @(negedge clk);
    set_id = sid; id_in = ID_SIZE'(idv); tag = ID_SIZE'(tg);
    pe_valid = pv; pe_data = pd; bus_ready = br;
    #1;
    check_outputs();
    do_push = pv && (mq.size() < DEPTH);
    do_pop  = (tg == m_id) && (mq.size() != 0) && br;
    if (do_pop) begin
      void'(mq.pop_front());
      m_sent = (m_sent + 1) % (1 << CNT_SIZE);
      n_pops++;
    end
    if (do_push) mq.push_back(pd);
    if (sid) begin
      m_id   = idv;
      m_sent = 0;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_id = 0; pe_valid = 0; bus_ready = 0;
    rst = 1'b1;
    #1;
    mq.delete(); m_id = 0; m_sent = 0;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; set_id = 0; id_in = '0; tag = '0; pe_valid = 0; pe_data = '0; bus_ready = 0;
    m_id = 0; m_sent = 0; n_pops = 0;
    #12;
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);                         // idle after reset

    // ID 5, push A1/A2, bus drains them on consecutive cycles.
    cyc(1, 5, 5, 0, 0, 1);
    cyc(0, 0, 5, 1, 32'hA1, 1);
    cyc(0, 0, 5, 1, 32'hA2, 1);
    cyc(0, 0, 5, 0, 0, 1);
    cyc(0, 0, 5, 0, 0, 1);
    chk("sent_after_two", 64'(sent_cnt), 64'd2);

    // Tag mismatch fills the FIFO; third word held; then drain 1,2,3.
    cyc(0, 0, 3, 1, 32'h1, 1);
    cyc(0, 0, 3, 1, 32'h2, 1);
    cyc(0, 0, 3, 1, 32'h3, 1);                     // not accepted
    chk("full_not_ready", 64'(pe_ready), 64'd0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 5, (mq.size() < DEPTH) && i == 1, 32'h3, 1);

    // Full FIFO drained while PE keeps pushing.
    for (int i = 0; i < 8; i++) cyc(0, 0, (i < 2) ? 3 : 5, 1, 32'hB0 + i, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 5, 0, 0, 1);

    // Backpressure: one word held for 10 cycles, then tag withdrawn.
    cyc(0, 0, 5, 1, 32'hC0FFEE, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 5, 0, 0, 0);
    cyc(0, 0, 9, 0, 0, 1);
    cyc(0, 0, 5, 0, 0, 1);

    // Reset with words queued and sent_cnt nonzero.
    while (m_sent < 7) cyc(0, 0, 5, 1, $urandom, 1);
    cyc(0, 0, 2, 1, 32'hD1, 0);
    cyc(0, 0, 2, 1, 32'hD2, 0);
    do_reset();
    cyc(1, 5, 5, 0, 0, 1);
    cyc(0, 0, 5, 0, 0, 1);                         // no stale words
    cyc(0, 0, 5, 1, 32'hE1, 0);
    cyc(1, 6, 5, 0, 0, 1);                         // set_id during pop
    cyc(0, 0, 6, 0, 0, 0);

    // Randomized traffic with occasional ID reloads and resets.
    for (int i = 0; i < 3000; i++) begin
      int tg;
      tg = ($urandom_range(0, 9) < 7) ? m_id : int'($urandom_range(0, 31));
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc($urandom_range(0, 39) == 0, int'($urandom_range(0, 31)), tg,
          $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) != 0);
    end
    chk("random_pops_seen", 64'(n_pops > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gon_collect_controller.md
Name: gon_collect_controller

Overview:
- PE-side output controller for the global output network (GON). It is the return direction of the GIN multicast path.
- Accepts result words from one PE through a valid/ready handshake and buffers them in a small FIFO.
- Presents buffered words to the shared output bus only while the bus tag equals the controller's configured ID.
- One instance per PE. The ID is programmed at configuration time, in the same way as the GIN controllers.

Parameters:
- ID_SIZE, 5, width of the ID and tag fields (`XID_BITS).
- DATA_SIZE, 32, width of a result word.
- DEPTH, 2, FIFO entries. Must be a power of two and at least 2.
- CNT_SIZE, 16, width of the sent-word counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- set_id  in  1  load id_in into the ID register.
- id_in  in  ID_SIZE  ID to load.
- id  out  ID_SIZE  current ID register.
- tag  in  ID_SIZE  bus destination tag for the current cycle.
- pe_valid  in  1  PE offers pe_data.
- pe_data  in  DATA_SIZE  result word from the PE.
- pe_ready  out  1  controller can accept a word.
- bus_ready  in  1  bus accepts a word.
- bus_valid  out  1  controller offers bus_data.
- bus_data  out  DATA_SIZE  word at the FIFO head.
- pending  out  $clog2(DEPTH)+1  number of FIFO entries occupied.
- sent_cnt  out  CNT_SIZE  words accepted by the bus since the last set_id or reset.

Behaviour:
- Reset (rst=1, takes effect immediately):
  - id=0, FIFO empty, pending=0, sent_cnt=0, read/write pointers 0.
  - Resulting outputs: bus_valid=0, bus_data=0, pe_ready=1.
  - Reset asserted mid-transfer discards all queued words without emitting them.
- ID register:
  - On set_id=1, id<=id_in at the next edge; otherwise id holds.
  - set_id also clears sent_cnt to 0. If the bus pops a word in the same cycle, sent_cnt still ends at 0.
  - Queued words are retained across set_id and are emitted under the new ID.
- Push side:
  - pe_ready = (pending < DEPTH). It is a registered-state function only, with no combinational path from bus_ready or tag.
  - A push occurs when pe_valid && pe_ready. The word is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Pop side:
  - bus_valid = (tag == id) && (pending != 0). This is combinational, the same gating as the GIN controller.
  - bus_data = FIFO head when pending != 0, else 0. bus_data is not gated by the tag match.
  - A pop occurs when bus_valid && bus_ready. rd_ptr advances and wraps modulo DEPTH. sent_cnt increments, wrapping at 2^CNT_SIZE.
- Simultaneous push and pop in one cycle: pending is unchanged and both pointers advance.
  - When full, pe_ready=0, so there is no push that cycle even if a pop occurs. The slot frees on the next cycle.
  - When empty, a pushed word is not visible on the bus until the following cycle. There is no bypass, so minimum latency from PE to bus is 1 cycle.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Tag mismatch: bus_valid=0, and bus_ready is ignored. A tag change while bus_valid=1 without bus_ready withdraws the valid; this is permitted on the GON bus.
- pending ranges 0..DEPTH and never exceeds DEPTH.

Test Plan:
- Reset then idle → id=0, pe_ready=1, bus_valid=0, pending=0, sent_cnt=0.
- set_id with id_in=5, push 0xA1 then 0xA2, tag=5, bus_ready=1 → bus_valid rises one cycle after the first push. Bus accepts A1 then A2 on consecutive cycles. sent_cnt=2, pending=0.
- Push 3 words with DEPTH=2 and tag=3 (≠5) → pending=2, pe_ready=0 after the second push, bus_valid=0. The third word is held by the PE. Switching tag to 5 emits words 1, 2, 3 in order.
- Full FIFO, tag=5, bus_ready=1 with pe_valid held → a pop occurs each cycle. pe_ready returns the cycle after the first pop. Order is preserved with no drops.
- bus_ready=0 with tag matching and 1 word queued → bus_valid stays 1 and pending stays 1 for 10 cycles. Changing tag drops bus_valid the same cycle while the data is retained.
- Assert rst with 2 words queued and sent_cnt=7 → pending=0, sent_cnt=0, id=0, bus_valid=0 immediately. After release, no stale words appear. set_id during a pop → sent_cnt=0 on the next cycle.
